numconv_serial: RTL and testbench
=================================

# numconv_serial

Bit-serial, parametrised number-format converter between two's complement (C2) and sign-magnitude (SM), selectable per operation. It is the sequential, W-bit successor of the combinational 8-bit C2-to-SM converter. It processes one magnitude bit per clock, LSB first, and sits in the arithmetic datapath next to the sequential multiplier and divider, which consume SM operands. It flags the non-representable C2 minimum.

## Interface
- W, default 8: word width in bits, including sign; legal range W >= 2.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  operation request; sampled only in IDLE.
- mode  input  1  0 = C2 to SM, 1 = SM to C2; captured with start.
- x  input  W  operand; captured with start.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle completion pulse.
- y  output  W  result; valid from done, held until the next accepted start.
- ovf  output  1  result not exactly representable; valid and held like y.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE → SHIFT on a clk edge with start=1:
  - Capture x, mode and sign s = x[W-1].
  - Clear the bit counter, seen-one flag, y and ovf.
- SHIFT: one edge per bit i = 0..W-2, LSB first.
  - neg = s. In mode 0, neg is the C2 sign; in mode 1, neg is the SM sign.
  - If neg=0, y[i] = x[i].
  - If neg=1, apply serial negation: y[i] = x[i] while no 1 has yet been seen at a lower bit, else y[i] = ~x[i]. The seen-one flag is set when x[i]=1.
  - After bit W-2, go to DONE.
- Sign bit, set on the SHIFT → DONE edge:
  - Mode 0: y[W-1] = s.
  - Mode 1: y[W-1] = s & (seen-one flag), so negative zero (1 followed by zeros) normalises to 0.
- C2 minimum in mode 0 (x = 1 followed by zeros): ovf=1 and y = 1 followed by zeros. SATURATE_EN modifies this case; see Configuration.
- Mode 1 never sets ovf.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- start is ignored in SHIFT and DONE. x and mode may change freely after capture without effect.
- Reset values, asynchronous: state IDLE, busy 0, done 0, y 0, ovf 0, counter 0, seen-one flag 0.
- Reset mid-operation aborts the operation: no done pulse and no partial y is retained.

## Timing
- Capture edge E. SHIFT covers edges E+1 .. E+W-1. done is high in the cycle after edge E+W-1.
- With W=8, done is visible 7 edges after capture.
- Earliest next capture: edge E+W+1, the first IDLE edge. Throughput is one operation per W+1 cycles.
- y and ovf change only on the SHIFT → DONE edge, during SHIFT, or on capture (cleared). They are stable from done until the next capture.
- A start held continuously high re-captures on every IDLE edge.

## Configuration
- SATURATE_EN, macro name NUMCONV_SATURATE_EN.
  - Defined: in mode 0, the C2 minimum saturates to y = all ones, i.e. -(2^(W-1)-1) in SM, with ovf=1.
  - Undefined: the C2 minimum yields y = 1 followed by zeros with ovf=1.
- All other behaviour and timing are identical in both builds.

## Test plan
- W=8, mode 0, x=0x05 → y=0x05, ovf=0, done exactly 7 edges after capture. Then x=0xFB → y=0x85. Then x=0x81 → y=0xFF.
- W=8, mode 0, x=0x00 → y=0x00. Then x=0x7F → y=0x7F, ovf=0. Then x=0x80 → y=0x80, ovf=1; with NUMCONV_SATURATE_EN, y=0xFF, ovf=1.
- W=8, mode 1, x=0x85 → y=0xFB. Then x=0xFF → y=0x81. Then x=0x80 → y=0x00, ovf=0.
- W=8, start held high with x toggled during SHIFT → results match the captured x only. Consecutive captures occur 9 edges apart. Exactly one done pulse per operation.
- rst pulsed mid-SHIFT, without waiting for a clk edge → busy, done, y and ovf are 0 immediately. No done follows. The next operation, mode 0 with x=0xFB, returns y=0x85.
- W=2, mode 0, all four inputs → 00→00, 01→01, 10→10 with ovf=1 (with NUMCONV_SATURATE_EN: 11 with ovf=1), 11→11. done is 1 edge after capture.

Source files
------------

// File: rtl/numconv_serial_if.sv
// numconv_serial_if: request/response bundle for the bit-serial C2 <-> SM
// converter.
//   start, mode, x : request, driven by the master
//   busy, done     : status, driven by the slave
//   y, ovf         : result, driven by the slave
// Modports: master (requester side), slave (converter side).
interface numconv_serial_if #(
    parameter int W = 8
);
    logic         start;
    logic         mode;
    logic [W-1:0] x;
    logic         busy;
    logic         done;
    logic [W-1:0] y;
    logic         ovf;

    modport master (output start, mode, x, input busy, done, y, ovf);
    modport slave  (input start, mode, x, output busy, done, y, ovf);
endinterface

// File: rtl/numconv_serial.sv
// numconv_serial: bit-serial W-bit converter between two's complement (C2)
// and sign-magnitude (SM). It handles one magnitude bit per clock, LSB
// first, and flags the non-representable C2 minimum.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : numconv_serial_if.slave (start/mode/x in, busy/done/y/ovf out)
// Optional feature macro: NUMCONV_SATURATE_EN. When it is defined, the C2
// minimum in mode 0 saturates to all ones (SM -(2^(W-1)-1)) instead of
// producing 1 followed by zeros. ovf is set in both builds.
module numconv_serial #(
    parameter int W = 8
) (
    input  logic clk,
    input  logic rst,
    numconv_serial_if.slave bus
);

`ifdef NUMCONV_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // The counter must reach W-2. It needs at least one bit, even when W=2.
    localparam int CW = (W > 2) ? $clog2(W - 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 2);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  xr;
    logic          mode_r;
    logic          s;
    logic          seen;
    logic [CW-1:0] cnt;
    logic [W-1:0]  y_r;
    logic          ovf_r;
    logic          busy_o, done_o;

    logic cur_bit, out_bit, seen_nxt, last, c2_min;

    // Serial negation: copy the bits up to and including the first 1, then
    // invert. This applies only for a negative operand. The sign is the C2
    // sign in mode 0 and the SM sign in mode 1.
    always_comb begin
        cur_bit  = xr[cnt];
        out_bit  = cur_bit ^ (s & seen);
        seen_nxt = seen | cur_bit;
        last     = (cnt == LAST);
        // Sign set and no 1 in the magnitude bits. In mode 0 this is the C2 minimum.
        c2_min   = ~mode_r & s & ~seen_nxt;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (last)      state_nxt = DONE;
            DONE:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state)
            SHIFT: busy_o = 1'b1;
            DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xr     <= '0;
            mode_r <= 1'b0;
            s      <= 1'b0;
            seen   <= 1'b0;
            cnt    <= '0;
            y_r    <= '0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    xr     <= bus.x;
                    mode_r <= bus.mode;
                    s      <= bus.x[W-1];
                    seen   <= 1'b0;
                    cnt    <= '0;
                    y_r    <= '0;
                    ovf_r  <= 1'b0;
                end
                SHIFT: begin
                    y_r[cnt] <= out_bit;
                    seen     <= seen_nxt;
                    cnt      <= cnt + 1'b1;
                    if (last) begin
                        ovf_r <= c2_min;
                        if (c2_min && SAT)
                            y_r <= '1;
                        else
                            // In mode 1, negative zero becomes +0.
                            y_r[W-1] <= mode_r ? (s & seen_nxt) : s;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_o;
    assign bus.done = done_o;
    assign bus.y    = y_r;
    assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_numconv_serial.sv
// tb_numconv_serial: directed-vector bench for numconv_serial. It drives a
// W=8 instance and a W=2 instance on a shared clock and reset.
module tb_numconv_serial;

`ifdef NUMCONV_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    numconv_serial_if #(.W(8)) bus8 ();
    numconv_serial_if #(.W(2)) bus2 ();

    numconv_serial #(.W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    numconv_serial #(.W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Issue one W=8 operation. Check the latency, y, ovf and the one-cycle done pulse.
    task automatic run8(input string tag, input logic m, input logic [7:0] xv,
                        input logic [7:0] ey, input logic eo);
        int lat;
        @(negedge clk);
        bus8.start = 1'b1; bus8.mode = m; bus8.x = xv;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        bus8.x = ~xv; bus8.mode = ~m;   // changes after capture must not matter
        lat = 0;
        while (!bus8.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".lat"}, lat, 7);
        chk({tag, ".y"}, bus8.y, ey);
        chk({tag, ".ovf"}, bus8.ovf, eo);
        @(posedge clk); #1;
        chk({tag, ".done1"}, bus8.done, 0);
        chk({tag, ".yhold"}, bus8.y, ey);
    endtask

    task automatic run2(input string tag, input logic [1:0] xv,
                        input logic [1:0] ey, input logic eo);
        int lat;
        @(negedge clk);
        bus2.start = 1'b1; bus2.mode = 1'b0; bus2.x = xv;
        @(posedge clk); #1;
        bus2.start = 1'b0;
        lat = 0;
        while (!bus2.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".lat"}, lat, 1);
        chk({tag, ".y"}, bus2.y, ey);
        chk({tag, ".ovf"}, bus2.ovf, eo);
        @(posedge clk); #1;
    endtask

    initial begin
        int dones, caps, cap_edge[2], nres;
        logic [7:0] yres[2];
        logic pbusy;

        bus8.start = 0; bus8.mode = 0; bus8.x = '0;
        bus2.start = 0; bus2.mode = 0; bus2.x = '0;
        #12;
        chk("rst.busy", bus8.busy, 0);
        chk("rst.done", bus8.done, 0);
        chk("rst.y", bus8.y, 0);
        chk("rst.ovf", bus8.ovf, 0);
        @(negedge clk); rst = 1'b0;

        // mode 0: C2 -> SM
        run8("c2sm_05", 0, 8'h05, 8'h05, 0);
        run8("c2sm_fb", 0, 8'hFB, 8'h85, 0);
        run8("c2sm_81", 0, 8'h81, 8'hFF, 0);
        run8("c2sm_00", 0, 8'h00, 8'h00, 0);
        run8("c2sm_7f", 0, 8'h7F, 8'h7F, 0);
        run8("c2sm_80", 0, 8'h80, SAT ? 8'hFF : 8'h80, 1);
        // mode 1: SM -> C2
        run8("smc2_85", 1, 8'h85, 8'hFB, 0);
        run8("smc2_ff", 1, 8'hFF, 8'h81, 0);
        run8("smc2_80", 1, 8'h80, 8'h00, 0);

        // Hold start high and scramble x during SHIFT. Captures occur at edges 1 and 10.
        dones = 0; caps = 0; nres = 0; pbusy = 0;
        for (int e = 1; e <= 18; e++) begin
            @(negedge clk);
            bus8.start = 1'b1; bus8.mode = 1'b0;
            if (e == 1)       bus8.x = 8'h05;
            else if (e == 10) bus8.x = 8'hFB;
            else              bus8.x = 8'hFF ^ 8'(e * 37);
            @(posedge clk); #1;
            if (bus8.busy && !pbusy) begin
                if (caps < 2) cap_edge[caps] = e;
                caps++;
            end
            pbusy = bus8.busy;
            if (bus8.done) begin
                if (nres < 2) yres[nres] = bus8.y;
                nres++;
                dones++;
            end
        end
        @(negedge clk); bus8.start = 1'b0;
        chk("hold.caps", caps, 2);
        chk("hold.dones", dones, 2);
        chk("hold.space", cap_edge[1] - cap_edge[0], 9);
        chk("hold.y0", yres[0], 8'h05);
        chk("hold.y1", yres[1], 8'h85);
        repeat (2) @(posedge clk);

        // Assert reset in the middle of SHIFT, between clock edges.
        @(negedge clk);
        bus8.start = 1'b1; bus8.mode = 1'b0; bus8.x = 8'hFB;
        @(posedge clk); #1; bus8.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort.busy", bus8.busy, 0);
        chk("abort.done", bus8.done, 0);
        chk("abort.y", bus8.y, 0);
        chk("abort.ovf", bus8.ovf, 0);
        @(negedge clk); rst = 1'b0;
        dones = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            if (bus8.done) dones++;
        end
        chk("abort.nodone", dones, 0);
        run8("after_abort", 0, 8'hFB, 8'h85, 0);

        // Run all four inputs through the W=2 instance.
        run2("w2_00", 2'b00, 2'b00, 0);
        run2("w2_01", 2'b01, 2'b01, 0);
        run2("w2_10", 2'b10, SAT ? 2'b11 : 2'b10, 1);
        run2("w2_11", 2'b11, 2'b11, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
